// File: rtl/spu_pkg.sv
// ============================================================================
// Module      : spu_pkg
// Description : Shared types and constants for the SPU writeback/forward stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spu_pkg;

  localparam int SPU_MAX_LAT = 7;
  localparam int SPU_REG_W   = 7;
  localparam int SPU_DATA_W  = 128;

  typedef struct packed {
    logic                  we;
    logic [SPU_REG_W-1:0]  rt;
    logic [2:0]            unit;
    logic [2:0]            lat;
    logic [SPU_DATA_W-1:0] data;
  } result_pkt_t;

  // Age of an entry at stage k is k+1; latencies 0 and 1 both mean "ready at stage 0".
  function automatic logic pkt_avail(input result_pkt_t p, input int stage);
    int eff;
    eff = (p.lat <= 3'd1) ? 1 : int'(p.lat);
    return ((stage + 1) >= eff);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fwd_lookup.sv
// ============================================================================
// Module      : fwd_lookup
// Description : Priority search of one operand query over both pipe chains.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_lookup
  import spu_pkg::*;
#(
  parameter int DEPTH = 7
) (
  input  result_pkt_t [DEPTH-1:0]   i_chain1,
  input  result_pkt_t [DEPTH-1:0]   i_chain2,
  input  logic [SPU_REG_W-1:0]      i_query_rt,
  output logic                      o_hit,
  output logic                      o_stall,
  output logic [SPU_DATA_W-1:0]     o_data
);

  logic                  w_match;
  logic                  w_avail;
  logic [SPU_DATA_W-1:0] w_data;

  // Walk oldest to youngest so the last match wins; pipe 2 overrides pipe 1 in a stage.
  always_comb begin
    w_match = 1'b0;
    w_avail = 1'b0;
    w_data  = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (i_chain1[k].we && (i_chain1[k].rt == i_query_rt)) begin
        w_match = 1'b1;
        w_avail = pkt_avail(i_chain1[k], k);
        w_data  = i_chain1[k].data;
      end
      if (i_chain2[k].we && (i_chain2[k].rt == i_query_rt)) begin
        w_match = 1'b1;
        w_avail = pkt_avail(i_chain2[k], k);
        w_data  = i_chain2[k].data;
      end
    end
  end

  assign o_hit   = w_match & w_avail;
  assign o_stall = w_match & ~w_avail;
  assign o_data  = (w_match & w_avail) ? w_data : '0;

endmodule

`default_nettype wire

// File: rtl/spu_writeback_forward.sv
// ============================================================================
// Module      : spu_writeback_forward
// Description : Dual-pipe result shift chains with writeback and forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spu_writeback_forward
  import spu_pkg::*;
#(
  parameter int DEPTH = 7,
  parameter int NQ    = 6
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             regWriteEnable_in1,
  input  logic [SPU_DATA_W-1:0]            result_in1,
  input  logic [SPU_REG_W-1:0]             registerRT_in1,
  input  logic [2:0]                       unitID_in1,
  input  logic [2:0]                       latency_in1,
  input  logic                             regWriteEnable_in2,
  input  logic [SPU_DATA_W-1:0]            result_in2,
  input  logic [SPU_REG_W-1:0]             registerRT_in2,
  input  logic [2:0]                       unitID_in2,
  input  logic [2:0]                       latency_in2,
  input  logic [NQ-1:0][SPU_REG_W-1:0]     query_rt,
  output logic [NQ-1:0]                    fwd_hit,
  output logic [NQ-1:0]                    fwd_stall,
  output logic [NQ-1:0][SPU_DATA_W-1:0]    fwd_data,
  output logic                             regWriteEnable_wb1,
  output logic [SPU_REG_W-1:0]             registerRT_wb1,
  output logic [SPU_DATA_W-1:0]            result_wb1,
  output logic [2:0]                       unitID_wb1,
  output logic                             regWriteEnable_wb2,
  output logic [SPU_REG_W-1:0]             registerRT_wb2,
  output logic [SPU_DATA_W-1:0]            result_wb2,
  output logic [2:0]                       unitID_wb2
);

  result_pkt_t               w_pkt1;
  result_pkt_t               w_pkt2;
  result_pkt_t [DEPTH-1:0]   r_chain1;
  result_pkt_t [DEPTH-1:0]   r_chain2;
  result_pkt_t               w_last1;
  result_pkt_t               w_last2;
  logic                      w_collide;

  assign w_pkt1 = '{we: regWriteEnable_in1, rt: registerRT_in1, unit: unitID_in1,
                    lat: latency_in1, data: result_in1};
  assign w_pkt2 = '{we: regWriteEnable_in2, rt: registerRT_in2, unit: unitID_in2,
                    lat: latency_in2, data: result_in2};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_chain1 <= '0;
      r_chain2 <= '0;
    end else begin
      r_chain1 <= {r_chain1[DEPTH-2:0], w_pkt1};
      r_chain2 <= {r_chain2[DEPTH-2:0], w_pkt2};
    end
  end

  assign w_last1 = r_chain1[DEPTH-1];
  assign w_last2 = r_chain2[DEPTH-1];

  // Pipe 2 is later in program order, so its write supersedes pipe 1 on the same RT.
  assign w_collide = w_last1.we & w_last2.we & (w_last1.rt == w_last2.rt);

  assign regWriteEnable_wb1 = w_last1.we & ~w_collide;
  assign registerRT_wb1     = w_last1.rt;
  assign result_wb1         = w_last1.data;
  assign unitID_wb1         = w_last1.unit;

  assign regWriteEnable_wb2 = w_last2.we;
  assign registerRT_wb2     = w_last2.rt;
  assign result_wb2         = w_last2.data;
  assign unitID_wb2         = w_last2.unit;

  generate
    for (genvar q = 0; q < NQ; q++) begin : g_lookup
      fwd_lookup #(
        .DEPTH (DEPTH)
      ) u_fwd_lookup (
        .i_chain1   (r_chain1),
        .i_chain2   (r_chain2),
        .i_query_rt (query_rt[q]),
        .o_hit      (fwd_hit[q]),
        .o_stall    (fwd_stall[q]),
        .o_data     (fwd_data[q])
      );
    end
  endgenerate

endmodule

`default_nettype wire
